// File: rtl/uart_cmd_framer.sv
// Purpose: pack BYTES consecutive UART receiver bytes (MSB first) into one command word.
// Latency: cmd/cmd_rdy update on the edge after the last byte's accept cycle; clr_rx_rdy is same-cycle.
// Backpressure: while a completed word is held, rx_rdy is left pending at the receiver until clr_cmd_rdy.
module uart_cmd_framer #(
  parameter int  BYTES   = 3,
  parameter int  TIMEOUT = 50000,
  localparam int CMD_W   = 8 * BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_byte,
  output logic             clr_rx_rdy,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  output logic             frame_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      byte_cnt;
  logic [TW-1:0]      timer;
  // Only the first BYTES-1 bytes need storing; the last byte goes straight into cmd.
  logic [CMD_W-9:0]   asm_q;
  logic [CMD_W-1:0]   asm_nxt;
  logic               accept;
  logic               last;
  logic               tmo;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Accept/complete/timeout decode and next-state selection.
  always_comb begin
    state_nxt  = state;
    accept     = rx_rdy && (state != HOLD);
    last       = accept && (state == COLLECT) && (byte_cnt == CW'(BYTES - 1));
    tmo        = (state == COLLECT) && !accept && (timer == TW'(TIMEOUT - 1));
    asm_nxt    = {asm_q, rx_byte};
    clr_rx_rdy = accept;
    case (state)
      IDLE:    if (accept) state_nxt = COLLECT;
      COLLECT: begin
        if (last)     state_nxt = HOLD;
        else if (tmo) state_nxt = IDLE;
      end
      HOLD:    if (clr_cmd_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Assembly shift register, byte counter, inter-byte timer and output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q     <= '0;
      byte_cnt  <= '0;
      timer     <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= tmo;
      if (accept) begin
        asm_q    <= asm_nxt[CMD_W-9:0];
        timer    <= '0;
        byte_cnt <= last ? '0 : byte_cnt + 1'b1;
      end else if (tmo) begin
        // Partial frame is dropped; cmd keeps the last complete word.
        asm_q    <= '0;
        byte_cnt <= '0;
        timer    <= '0;
      end else if (state == COLLECT) begin
        timer <= timer + 1'b1;
      end
      if (last) begin
        cmd     <= asm_nxt;
        cmd_rdy <= 1'b1;
      end else if ((state == HOLD) && clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer with a short TIMEOUT; a receiver model drives bytes and
// a monitor pops expected command words from a queue whenever cmd_rdy rises.
module tb_uart_cmd_framer;

  localparam int BYTES   = 3;
  localparam int TIMEOUT = 40;
  localparam int CMD_W   = 8 * BYTES;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_rdy = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             clr_cmd_rdy = 1'b0;
  logic             clr_rx_rdy;
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             frame_err;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;
  int err_cnt = 0;
  logic [CMD_W-1:0] exp_q[$];
  logic cmd_rdy_q = 1'b0;

  uart_cmd_framer #(.BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_byte(rx_byte),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Monitor: count pulses, and score every new frame against the expected queue.
  always @(negedge clk) begin
    if (clr_rx_rdy) clr_cnt++;
    if (frame_err)  err_cnt++;
    if (cmd_rdy && !cmd_rdy_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected frame cmd=%h", cmd);
      end else begin
        logic [CMD_W-1:0] e;
        e = exp_q.pop_front();
        if (cmd !== e) begin
          errors++;
          $display("FAIL scoreboard: cmd=%h required %h", cmd, e);
        end
      end
    end
    cmd_rdy_q <= cmd_rdy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Called just after a rising edge; present a byte and hold it until consumed.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    rx_byte = b;
    rx_rdy  = 1'b1;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (clr_rx_rdy === 1'b1) got = 1;
    end
    if (got) begin
      @(posedge clk); #1;
    end
    rx_rdy = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_byte %h: clr_rx_rdy stayed 0 for 30 cycles, required 1", b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_cmd(input string name, input logic [CMD_W-1:0] e);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== e) begin
      errors++;
      $display("FAIL %s: cmd_rdy=%b cmd=%h required 1 %h", name, cmd_rdy, cmd, e);
    end
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL ack: cmd_rdy=%b required 0", cmd_rdy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (cmd !== '0 || cmd_rdy !== 1'b0 || frame_err !== 1'b0 || clr_rx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset: cmd=%h cmd_rdy=%b frame_err=%b clr_rx_rdy=%b required all 0",
               cmd, cmd_rdy, frame_err, clr_rx_rdy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int c0 = clr_cnt;
    exp_q.push_back(24'hA51234);
    send_byte(8'hA5); idle(10);
    send_byte(8'h12); idle(10);
    send_byte(8'h34);
    check_cmd("basic_latency", 24'hA51234);
    checks++;
    if (clr_cnt - c0 != 3) begin
      errors++;
      $display("FAIL basic_clr_pulses: got %0d required 3", clr_cnt - c0);
    end
    ack();
  endtask

  task automatic test_timeout();
    int n_err = -1;
    send_byte(8'h01); idle(3);
    send_byte(8'h02);
    for (int n = 0; n < TIMEOUT + 10 && n_err < 0; n++) begin
      @(negedge clk);
      if (frame_err === 1'b1) n_err = n;
    end
    checks++;
    if (n_err != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_delay: frame_err after %0d cycles required %0d", n_err, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_width: frame_err=%b required 0", frame_err);
    end
    checks++;
    if (cmd !== 24'hA51234 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cmd_kept: cmd=%h cmd_rdy=%b required a51234 0", cmd, cmd_rdy);
    end
    @(posedge clk); #1;
    exp_q.push_back(24'h0FF055);
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'h55);
    check_cmd("timeout_recover", 24'h0FF055);
    ack();
  endtask

  task automatic test_hold();
    logic [CMD_W-1:0] cmd0;
    int bad = 0;
    exp_q.push_back(24'h112233);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    cmd0 = cmd;
    rx_byte = 8'h77;
    rx_rdy  = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (clr_rx_rdy !== 1'b0 || cmd !== cmd0 || cmd_rdy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_backpressure: %0d bad cycles required 0", bad);
    end
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (clr_rx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL hold_clr_cycle: clr_rx_rdy=%b required 0", clr_rx_rdy);
    end
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (clr_rx_rdy !== 1'b1) begin
      errors++;
      $display("FAIL hold_pending_accept: clr_rx_rdy=%b required 1", clr_rx_rdy);
    end
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    exp_q.push_back(24'h778899);
    send_byte(8'h88); send_byte(8'h99);
    check_cmd("hold_next_frame", 24'h778899);
    ack();
  endtask

  task automatic test_timeout_edge();
    int e0 = err_cnt;
    exp_q.push_back(24'h5A6B7C);
    send_byte(8'h5A); idle(TIMEOUT - 1);
    send_byte(8'h6B); idle(TIMEOUT - 1);
    send_byte(8'h7C);
    check_cmd("timeout_edge_frame", 24'h5A6B7C);
    idle(3);
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL timeout_edge_err: frame_err pulses %0d required 0", err_cnt - e0);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h12); send_byte(8'h34);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd !== '0 || cmd_rdy !== 1'b0 || frame_err !== 1'b0 || clr_rx_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cmd=%h cmd_rdy=%b frame_err=%b clr_rx_rdy=%b required all 0",
               cmd, cmd_rdy, frame_err, clr_rx_rdy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(24'hAABBCC);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check_cmd("reset_mid_frame", 24'hAABBCC);
    ack();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb [6];
    bb = '{8'hDE, 8'hAD, 8'hBE, 8'h01, 8'h23, 8'h45};
    for (int f = 0; f < 2; f++) begin
      int c0 = clr_cnt;
      int miss = 0;
      exp_q.push_back({bb[3*f], bb[3*f+1], bb[3*f+2]});
      for (int i = 0; i < 3; i++) begin
        rx_byte = bb[3*f+i];
        rx_rdy  = 1'b1;
        @(negedge clk);
        if (clr_rx_rdy !== 1'b1) miss++;
        @(posedge clk); #1;
      end
      rx_rdy = 1'b0;
      checks++;
      if (miss != 0 || clr_cnt - c0 != 3) begin
        errors++;
        $display("FAIL b2b_accepts: missed=%0d pulses=%0d required 0 3", miss, clr_cnt - c0);
      end
      check_cmd("b2b_frame", {bb[3*f], bb[3*f+1], bb[3*f+2]});
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_hold();
    test_timeout_edge();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
